// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

  localparam logic [7:0]  KEY_EXT       = 8'hE0;
  localparam logic [7:0]  KEY_BRK       = 8'hF0;
  localparam logic [7:0]  KEY_PAUSE     = 8'hE1;
  localparam int unsigned PAUSE_SKIP    = 7;
  localparam int unsigned SKIP_WIDTH    = 3;
  localparam int unsigned FRAME_BITS    = 11;
  localparam int unsigned BIT_CNT_WIDTH = 4;
  localparam int unsigned N_IGNORED     = 5;

  // Keyboard status/ack bytes that never map to a key.
  localparam logic [N_IGNORED-1:0][7:0] IGNORED_CODES =
    {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [2:0] {
    PF_IDLE,
    PF_EXT,
    PF_BRK,
    PF_EXT_BRK,
    PF_PAUSE
  } pf_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_BUSY
  } rx_state_t;

  function automatic logic is_ignored(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_IGNORED; i++) begin
      if (code == IGNORED_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_byte_receiver.sv
// PS/2 frame receiver: synchronises the line pair, shifts in 11-bit frames,
// validates start/parity/stop and aborts stalled frames.
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned              TIMEOUT_WIDTH = 17,
  parameter logic [TIMEOUT_WIDTH-1:0] FRAME_TIMEOUT = TIMEOUT_WIDTH'(63000)
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_error
);

  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_data_s1, r_data_s2;

  rx_state_t                  r_state, w_state_next;
  logic [BIT_CNT_WIDTH-1:0]   r_bit_cnt;
  logic [7:0]                 r_shift;
  logic                       r_parity;
  logic [TIMEOUT_WIDTH-1:0]   r_tmo_cnt;

  logic w_fall, w_data, w_busy, w_timeout, w_last_bit, w_frame_ok;
  logic w_byte_valid_c, w_frame_error_c;

  // Idle line level is high, so syncs reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_s3  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_clk_s1  <= i_ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_data_s1 <= i_ps2_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_fall     = r_clk_s3 & ~r_clk_s2;
  assign w_data     = r_data_s2;
  assign w_busy     = (r_state == RX_BUSY);
  assign w_timeout  = w_busy & ~w_fall & (r_tmo_cnt == FRAME_TIMEOUT);
  assign w_last_bit = w_busy & w_fall &
                      (r_bit_cnt == BIT_CNT_WIDTH'(FRAME_BITS - 1));
  // Stop bit high and odd parity over data plus parity bit.
  assign w_frame_ok = w_data & (^{r_shift, r_parity});

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= RX_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE: if (w_fall && !w_data)        w_state_next = RX_BUSY;
      RX_BUSY: if (w_timeout || w_last_bit)  w_state_next = RX_IDLE;
      default:                               w_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_byte_valid_c  = w_last_bit & w_frame_ok;
    w_frame_error_c = (~w_busy & w_fall & w_data) | w_timeout |
                      (w_last_bit & ~w_frame_ok);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_tmo_cnt     <= '0;
      o_byte_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_byte_valid  <= w_byte_valid_c;
      o_frame_error <= w_frame_error_c;
      if (w_fall) begin
        r_tmo_cnt <= '0;
        if (!w_busy) begin
          r_bit_cnt <= BIT_CNT_WIDTH'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_CNT_WIDTH'(1);
          if (r_bit_cnt <= BIT_CNT_WIDTH'(8))
            r_shift <= {w_data, r_shift[7:1]};
          else if (r_bit_cnt == BIT_CNT_WIDTH'(9))
            r_parity <= w_data;
        end
      end else if (w_busy && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + TIMEOUT_WIDTH'(1);
      end
    end
  end

  assign o_byte = r_shift;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// Scan-code set 2 decoder: turns received bytes into 9-bit key codes with
// make/brake pulses; bit 8 flags E0-extended keys.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned              KEYCODE_WIDTH = 9,
  parameter int unsigned              TIMEOUT_WIDTH = 17,
  parameter logic [TIMEOUT_WIDTH-1:0] FRAME_TIMEOUT = TIMEOUT_WIDTH'(63000)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     ps2Clk,
  input  logic                     ps2Data,
  output logic [KEYCODE_WIDTH-1:0] keyCode,
  output logic                     make,
  output logic                     brake,
  output logic                     frameError
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_error;

  pf_state_t               r_state, w_state_next;
  logic [SKIP_WIDTH-1:0]   r_skip, w_skip_next;
  logic                    w_emit_make, w_emit_brake;
  logic [KEYCODE_WIDTH-1:0] w_code;
  logic                    w_prefix;

  ps2_byte_receiver #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .FRAME_TIMEOUT (FRAME_TIMEOUT)
  ) u_rx (
    .clk           (clk),
    .resetN        (resetN),
    .i_ps2_clk     (ps2Clk),
    .i_ps2_data    (ps2Data),
    .o_byte        (w_byte),
    .o_byte_valid  (w_byte_valid),
    .o_frame_error (w_frame_error)
  );

  assign w_prefix = (w_byte == KEY_EXT) || (w_byte == KEY_BRK);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= PF_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    if (w_frame_error) begin
      w_state_next = PF_IDLE;
    end else if (w_byte_valid) begin
      case (r_state)
        PF_IDLE: begin
          if (w_byte == KEY_EXT)        w_state_next = PF_EXT;
          else if (w_byte == KEY_BRK)   w_state_next = PF_BRK;
          else if (w_byte == KEY_PAUSE) begin
            w_state_next = PF_PAUSE;
            w_skip_next  = SKIP_WIDTH'(PAUSE_SKIP);
          end
        end
        PF_EXT: begin
          if (w_byte == KEY_BRK)        w_state_next = PF_EXT_BRK;
          else if (w_byte != KEY_EXT)   w_state_next = PF_IDLE;
        end
        PF_BRK: begin
          if (w_byte == KEY_EXT)        w_state_next = PF_EXT_BRK;
          else if (w_byte != KEY_BRK)   w_state_next = PF_IDLE;
        end
        PF_EXT_BRK: if (!w_prefix)      w_state_next = PF_IDLE;
        // Pause sends a fixed tail of bytes that carries no key information.
        PF_PAUSE: begin
          w_skip_next = r_skip - SKIP_WIDTH'(1);
          if (r_skip <= SKIP_WIDTH'(1)) w_state_next = PF_IDLE;
        end
        default:                        w_state_next = PF_IDLE;
      endcase
    end
  end

  always_comb begin
    w_emit_make  = 1'b0;
    w_emit_brake = 1'b0;
    w_code       = '0;
    if (w_byte_valid && !w_frame_error) begin
      case (r_state)
        PF_IDLE: begin
          if (!w_prefix && (w_byte != KEY_PAUSE) && !is_ignored(w_byte)) begin
            w_emit_make = 1'b1;
            w_code      = KEYCODE_WIDTH'({1'b0, w_byte});
          end
        end
        PF_EXT: begin
          if (!w_prefix) begin
            w_emit_make = 1'b1;
            w_code      = KEYCODE_WIDTH'({1'b1, w_byte});
          end
        end
        PF_BRK: begin
          if (!w_prefix) begin
            w_emit_brake = 1'b1;
            w_code       = KEYCODE_WIDTH'({1'b0, w_byte});
          end
        end
        PF_EXT_BRK: begin
          if (!w_prefix) begin
            w_emit_brake = 1'b1;
            w_code       = KEYCODE_WIDTH'({1'b1, w_byte});
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      keyCode <= '0;
      make    <= 1'b0;
      brake   <= 1'b0;
    end else begin
      make  <= w_emit_make;
      brake <= w_emit_brake;
      if (w_emit_make || w_emit_brake) keyCode <= w_code;
    end
  end

  assign frameError = w_frame_error;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Bench for ps2_keycode_decoder: vector table, directed corner sequences and
// random byte streams checked against a prefix-flag reference model.
`timescale 1ns/1ps
module tb_ps2_keycode_decoder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       resetN;
  logic       ps2Clk;
  logic       ps2Data;
  logic [8:0] keyCode;
  logic       make, brake, frameError;

  int checks   = 0;
  int failures = 0;

  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];
  int fe_seen   = 0;
  int fe_exp    = 0;
  int both_seen = 0;

  bit m_ext, m_brk;
  int m_skip;

  typedef struct {
    int          n;
    logic [23:0] bytes;
    bit          has_ev;
    logic [10:0] ev;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  ps2_keycode_decoder dut (
    .clk        (clk),
    .resetN     (resetN),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .keyCode    (keyCode),
    .make       (make),
    .brake      (brake),
    .frameError (frameError)
  );

  always @(negedge clk) begin
    if (resetN) begin
      if (make || brake) got_q.push_back({make, brake, keyCode});
      if (make && brake) both_seen++;
      if (frameError)    fe_seen++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: prefix flags accumulate until a non-prefix byte produces a key.
  function automatic void model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (!m_ext && !m_brk && b == 8'hE1) m_skip = 7;
    else if (!m_ext && !m_brk &&
             (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF)) ;
    else begin
      exp_q.push_back({~m_brk, m_brk, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_abort();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
    fe_exp++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2Data = v;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2Data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic check_events(input string name);
    repeat (8) @(negedge clk);
    check({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, " event"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({name, " frameError count"}, fe_seen, fe_exp);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [8:0]  last;
    logic [7:0]  b;
    logic [7:0]  seq [9];
    int          n, start;

    vecs[0] = '{1, 24'h00001C, 1'b1, {2'b10, 9'h01C}};
    vecs[1] = '{2, 24'h001CF0, 1'b1, {2'b01, 9'h01C}};
    vecs[2] = '{2, 24'h005AE0, 1'b1, {2'b10, 9'h15A}};
    vecs[3] = '{3, 24'h5AF0E0, 1'b1, {2'b01, 9'h15A}};
    vecs[4] = '{3, 24'h75E0E0, 1'b1, {2'b10, 9'h175}};
    vecs[5] = '{3, 24'h1CF0F0, 1'b1, {2'b01, 9'h01C}};
    vecs[6] = '{3, 24'h6BE0F0, 1'b1, {2'b01, 9'h16B}};
    vecs[7] = '{1, 24'h0000AA, 1'b0, 11'h000};
    vecs[8] = '{1, 24'h0000FF, 1'b0, 11'h000};
    vecs[9] = '{2, 24'h0000E0, 1'b1, {2'b10, 9'h100}};

    resetN  = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    repeat (5) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("reset keyCode", 32'(keyCode), 32'h0);
    check("reset make", 32'(make), 32'h0);
    check("reset brake", 32'(brake), 32'h0);
    check("reset frameError", 32'(frameError), 32'h0);

    last = 9'h000;
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        b = vecs[v].bytes[8*k +: 8];
        send_frame(b, 1'b0, 11);
      end
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d count", v), got_q.size(), vecs[v].has_ev ? 1 : 0);
      if (vecs[v].has_ev) begin
        if (got_q.size() > 0) check($sformatf("vec%0d event", v), 32'(got_q[0]), 32'(vecs[v].ev));
        last = vecs[v].ev[8:0];
      end
      check($sformatf("vec%0d keyCode", v), 32'(keyCode), 32'(last));
      got_q.delete();
    end

    // Even parity frame is dropped and keyCode holds.
    send_frame(8'h29, 1'b1, 11);
    model_abort();
    check_events("parity error");
    check("parity keyCode held", 32'(keyCode), 32'(last));
    send_byte(8'h29);
    check_events("after parity");
    check("after parity keyCode", 32'(keyCode), 32'h029);

    // Stalled frame after E0: timeout, prefix must be dropped.
    send_byte(8'hE0);
    send_frame(8'h5A, 1'b0, 4);
    n = HALF;
    start = fe_seen;
    while (fe_seen == start && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("timeout latency in window", 32'(n >= 63000 && n <= 63010), 32'h1);
    model_abort();
    check_events("timeout");
    send_byte(8'h5A);
    check_events("after timeout");
    check("after timeout keyCode", 32'(keyCode), 32'h05A);

    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    for (int i = 0; i < 9; i++) send_byte(seq[i]);
    check_events("pause");
    check("pause keyCode", 32'(keyCode), 32'h029);

    // Reset in the middle of a frame.
    send_frame(8'h1C, 1'b0, 6);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("midreset keyCode", 32'(keyCode), 32'h0);
    check("midreset make", 32'(make), 32'h0);
    check("midreset brake", 32'(brake), 32'h0);
    check("midreset frameError", 32'(frameError), 32'h0);
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    got_q.delete();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    send_byte(8'h1C);
    check_events("after midreset");
    check("after midreset keyCode", 32'(keyCode), 32'h01C);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h29;
        3:       b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 11) == 0) begin
        send_frame(b, 1'b1, 11);
        model_abort();
      end else begin
        send_byte(b);
      end
      if (i % 10 == 9) check_events($sformatf("random block %0d", i / 10));
    end

    check("make and brake overlap", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
